// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Types and helpers shared by the UART receive and transmit stages.
//   Contents:
//     rx_state_t / tx_state_t   FSM state encodings
//     parity_mode_t             parity-mode encoding (NONE / ODD / EVEN)
//     log2()                    ceiling log2, minimum result 1 (counter widths)
//     calc_bit_cyc()            clocks per bit period
//     calc_half_cyc()           clocks per half bit period
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE       = 3'd0,
    RX_START_BIT  = 3'd1,
    RX_SHIFT_DATA = 3'd2,
    RX_PARITY     = 3'd3,
    RX_STOP       = 3'd4,
    RX_DONE       = 3'd5
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE       = 3'd0,
    TX_START_BIT  = 3'd1,
    TX_SHIFT_DATA = 3'd2,
    TX_PARITY     = 3'd3,
    TX_STOP       = 3'd4
  } tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10
  } parity_mode_t;

  // Ceiling log2 with a floor of 1 so a counter always has at least one bit.
  function automatic int log2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int calc_bit_cyc(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

  function automatic int calc_half_cyc(input int clk_freq, input int bps);
    return (clk_freq / bps) / 2;
  endfunction

endpackage

// File: rtl/rxd_clk.sv
// ---------------------------------------------------------------------------
// rxd_clk
//   Restartable baud counter for the receiver. Counts 0..BIT_CYC-1 and wraps.
//   Ports:
//     clk        system clock
//     rst        synchronous active-high reset
//     restart    force the count back to 0 on the next edge
//     half_tick  count == HALF-1 (mid-point of the start bit)
//     bit_tick   count == BIT_CYC-1 (one full bit period since restart/wrap)
// ---------------------------------------------------------------------------
module rxd_clk
  import uart_pkg::*;
#(
  parameter int BIT_CYC = 10,
  parameter int HALF    = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic half_tick,
  output logic bit_tick
);

  localparam int CW = log2(BIT_CYC);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(BIT_CYC - 1);

  logic [CW-1:0] cnt;

  assign half_tick = (cnt == HALF_M1);
  assign bit_tick  = (cnt == BIT_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rxd.sv
// ---------------------------------------------------------------------------
// rxd
//   UART receive stage. Synchronizes uart_rx, detects the start edge, samples
//   each bit at mid-period, checks parity and stop bit, and presents the frame
//   with a one-cycle rx_done strobe.
//   Ports:
//     clk         system clock (rising edge)
//     rst         synchronous active-high reset
//     uart_rx     asynchronous serial line, idle high
//     data_frame  last received data, right-aligned (bit 0 = first bit on wire)
//     rx_done     one-cycle strobe: data_frame and error flags valid
//     parity_err  parity mismatch on last frame (always 0 for NONE)
//     frame_err   stop bit sampled low on last frame
//
//   state         | meaning
//   --------------+-----------------------------------------------------------
//   RX_IDLE       | waiting for a falling edge on the synchronized line
//   RX_START_BIT  | waiting for start-bit centre; high there = false start
//   RX_SHIFT_DATA | sampling FRAME_WD data bits, one per bit period
//   RX_PARITY     | sampling the parity bit (only when parity is enabled)
//   RX_STOP       | sampling the stop bit
//   RX_DONE       | one cycle: publish frame and flags, pulse rx_done
// ---------------------------------------------------------------------------
module rxd
  import uart_pkg::*;
#(
  parameter int    CLK_FREQUENCE = 50_000_000,
  parameter int    BPS           = 9600,
  parameter string PARITY_BIT    = "NONE",
  parameter int    FRAME_WD      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                uart_rx,
  output logic [FRAME_WD-1:0] data_frame,
  output logic                rx_done,
  output logic                parity_err,
  output logic                frame_err
);

  localparam int BIT_CYC = calc_bit_cyc(CLK_FREQUENCE, BPS);
  localparam int HALF    = calc_half_cyc(CLK_FREQUENCE, BPS);

  localparam parity_mode_t PMODE = (PARITY_BIT == "ODD")  ? PAR_ODD  :
                                   (PARITY_BIT == "EVEN") ? PAR_EVEN : PAR_NONE;
  localparam logic HAS_PAR = (PMODE != PAR_NONE);
  // XOR(data, parity bit) value that flags an error.
  localparam logic PAR_BAD = (PMODE == PAR_EVEN);

  localparam logic [2:0] LAST_BIT = 3'(FRAME_WD - 1);

  if (FRAME_WD < 5 || FRAME_WD > 8) begin : g_bad_frame_wd
    $error("rxd: FRAME_WD must be in 5..8");
  end

  // Synchronizer plus one history flop for edge detection; all idle high.
  logic sync1;
  logic sync2;
  logic sync2_d;
  logic fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      sync2_d <= 1'b1;
    end else begin
      sync1   <= uart_rx;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign fall = !sync2 && sync2_d;

  rx_state_t  state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       par_err_r;
  logic       frm_err_r;
  logic       restart;
  logic       half_tick;
  logic       bit_tick;

  // Realign the baud counter at the start edge and again at the start-bit
  // centre so every later bit_tick lands at a bit centre.
  always_comb begin
    restart = 1'b0;
    if (state == RX_IDLE && fall) begin
      restart = 1'b1;
    end else if (state == RX_START_BIT && half_tick && !sync2) begin
      restart = 1'b1;
    end
  end

  rxd_clk #(
    .BIT_CYC (BIT_CYC),
    .HALF    (HALF)
  ) u_rxd_clk (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .half_tick (half_tick),
    .bit_tick  (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RX_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      par_err_r  <= 1'b0;
      frm_err_r  <= 1'b0;
      data_frame <= '0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (fall) state <= RX_START_BIT;
        end

        RX_START_BIT: begin
          if (half_tick) begin
            if (sync2) begin
              state <= RX_IDLE;
            end else begin
              state     <= RX_SHIFT_DATA;
              bit_cnt   <= '0;
              par_err_r <= 1'b0;
            end
          end
        end

        RX_SHIFT_DATA: begin
          if (bit_tick) begin
            shreg   <= {sync2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) begin
              state <= HAS_PAR ? RX_PARITY : RX_STOP;
            end
          end
        end

        RX_PARITY: begin
          if (bit_tick) begin
            par_err_r <= ((^shreg[7 -: FRAME_WD]) ^ sync2) == PAR_BAD;
            state     <= RX_STOP;
          end
        end

        RX_STOP: begin
          if (bit_tick) begin
            frm_err_r <= !sync2;
            state     <= RX_DONE;
          end
        end

        RX_DONE: begin
          // A short frame sits in the top FRAME_WD bits after right shifts.
          data_frame <= shreg[7 -: FRAME_WD];
          parity_err <= par_err_r;
          frame_err  <= frm_err_r;
          rx_done    <= 1'b1;
          state      <= RX_IDLE;
        end

        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rxd.sv
module tb_rxd;

  localparam int CF   = 1_000_000;
  localparam int BR   = 100_000;
  localparam int BC   = 10;
  localparam int HB   = 5;
  localparam int FW_OF [3] = '{8, 8, 5};
  localparam int PM_OF [3] = '{0, 1, 2};   // 0 none, 1 odd, 2 even

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] line;
  logic [7:0] df0, df1;
  logic [4:0] df2;
  logic [2:0] done, pe, fe;

  always #5 clk = ~clk;

  rxd #(.CLK_FREQUENCE(CF), .BPS(BR), .PARITY_BIT("NONE"), .FRAME_WD(8)) u_none (
    .clk(clk), .rst(rst), .uart_rx(line[0]), .data_frame(df0),
    .rx_done(done[0]), .parity_err(pe[0]), .frame_err(fe[0]));

  rxd #(.CLK_FREQUENCE(CF), .BPS(BR), .PARITY_BIT("ODD"), .FRAME_WD(8)) u_odd (
    .clk(clk), .rst(rst), .uart_rx(line[1]), .data_frame(df1),
    .rx_done(done[1]), .parity_err(pe[1]), .frame_err(fe[1]));

  rxd #(.CLK_FREQUENCE(CF), .BPS(BR), .PARITY_BIT("EVEN"), .FRAME_WD(5)) u_even5 (
    .clk(clk), .rst(rst), .uart_rx(line[2]), .data_frame(df2),
    .rx_done(done[2]), .parity_err(pe[2]), .frame_err(fe[2]));

  typedef struct {
    int         inst;
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         cyc;
  } obs_t;

  obs_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic [2:0] done_d = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe; flag any strobe lasting two cycles.
  always @(negedge clk) begin
    obs_t o;
    for (int i = 0; i < 3; i++) begin
      if (done[i] === 1'b1) begin
        o.inst = i;
        o.d    = (i == 0) ? df0 : (i == 1) ? df1 : {3'b000, df2};
        o.pe   = pe[i];
        o.fe   = fe[i];
        o.cyc  = cyc;
        q.push_back(o);
        n_checks++;
        if (done_d[i] === 1'b1) begin
          n_fail++;
          $display("FAIL strobe_width inst %0d: rx_done high 2 cycles in a row, required 1", i);
        end
      end
    end
    done_d <= done;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int ones(input logic [7:0] d, input int fw);
    int n = 0;
    for (int b = 0; b < fw; b++) n += int'(d[b]);
    return n;
  endfunction

  function automatic logic good_par(input int pm, input logic [7:0] d, input int fw);
    if (pm == 1) return (ones(d, fw) % 2 == 0);
    return (ones(d, fw) % 2 == 1);
  endfunction

  function automatic logic exp_perr(input int pm, input logic [7:0] d, input int fw, input logic pbit);
    int total;
    total = ones(d, fw) + int'(pbit);
    if (pm == 0) return 1'b0;
    if (pm == 1) return (total % 2 == 0);
    return (total % 2 == 1);
  endfunction

  function automatic int exp_lat(input int fw, input int pm);
    return 3 + HB + (fw + ((pm != 0) ? 1 : 0) + 1) * BC;
  endfunction

  function automatic logic [7:0] get_df(input int sel);
    if (sel == 0) return df0;
    if (sel == 1) return df1;
    return {3'b000, df2};
  endfunction

  // ---------------- drivers ----------------
  // Called at a negedge; leaves the line at the stop level on return.
  task automatic send_frame(input int sel, input logic [7:0] data, input logic pbit,
                            input logic stop_v, output int start_cyc);
    line[sel] = 1'b0;
    start_cyc = cyc;
    repeat (BC) @(negedge clk);
    for (int b = 0; b < FW_OF[sel]; b++) begin
      line[sel] = data[b];
      repeat (BC) @(negedge clk);
    end
    if (PM_OF[sel] != 0) begin
      line[sel] = pbit;
      repeat (BC) @(negedge clk);
    end
    line[sel] = stop_v;
    repeat (BC) @(negedge clk);
  endtask

  task automatic pop_strobe(input int sel, input int budget, output logic found, output obs_t o);
    found = 1'b0;
    o = '{inst: -1, d: 8'h00, pe: 1'b0, fe: 1'b0, cyc: 0};
    for (int k = 0; k <= budget && !found; k++) begin
      for (int j = 0; j < q.size(); j++) begin
        if (q[j].inst == sel) begin
          o = q[j];
          q.delete(j);
          found = 1'b1;
          break;
        end
      end
      if (!found) @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst  = 1'b1;
    line = 3'b111;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({df0, df1, df2} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h/%h, required 0/0/0", df0, df1, df2);
    end
    n_checks++;
    if (done !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_done: got %b, required 000", done);
    end
    n_checks++;
    if (pe !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_parity_err: got %b, required 000", pe);
    end
    n_checks++;
    if (fe !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_frame_err: got %b, required 000", fe);
    end
  endtask

  task automatic test_none_a5();
    int sc; logic found; obs_t o;
    q.delete();
    send_frame(0, 8'hA5, 1'b1, 1'b1, sc);
    pop_strobe(0, 20, found, o);
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL a5_strobe: got no rx_done, required one");
    end else begin
      n_checks++;
      if ({o.d, o.pe, o.fe} !== {8'hA5, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL a5_frame: got d=%h pe=%b fe=%b, required d=a5 pe=0 fe=0", o.d, o.pe, o.fe);
      end
      n_checks++;
      if (o.cyc - sc - 1 != exp_lat(8, 0)) begin
        n_fail++;
        $display("FAIL a5_latency: got %0d, required %0d", o.cyc - sc - 1, exp_lat(8, 0));
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_odd_parity();
    int sc; logic found; obs_t o;
    for (int t = 0; t < 2; t++) begin
      q.delete();
      send_frame(1, 8'h03, (t == 0) ? 1'b1 : 1'b0, 1'b1, sc);
      pop_strobe(1, 20, found, o);
      n_checks++;
      if (!found) begin
        n_fail++;
        $display("FAIL odd_strobe%0d: got no rx_done, required one", t);
      end else begin
        n_checks++;
        if ({o.d, o.pe, o.fe} !== {8'h03, (t == 1), 1'b0}) begin
          n_fail++;
          $display("FAIL odd_frame%0d: got d=%h pe=%b fe=%b, required d=03 pe=%0d fe=0",
                   t, o.d, o.pe, o.fe, t);
        end
        n_checks++;
        if (o.cyc - sc - 1 != exp_lat(8, 1)) begin
          n_fail++;
          $display("FAIL odd_latency%0d: got %0d, required %0d", t, o.cyc - sc - 1, exp_lat(8, 1));
        end
      end
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic test_break();
    int sc; logic found; obs_t o;
    q.delete();
    send_frame(0, 8'h5A, 1'b1, 1'b0, sc);
    pop_strobe(0, 20, found, o);
    n_checks++;
    if (!found || {o.d, o.pe, o.fe} !== {8'h5A, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL break_frame: got found=%b d=%h pe=%b fe=%b, required d=5a pe=0 fe=1",
               found, o.d, o.pe, o.fe);
    end
    repeat (30) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL break_spurious: got %0d strobes during break, required 0", q.size());
    end
    line[0] = 1'b1;
    repeat (BC) @(negedge clk);
    send_frame(0, 8'h11, 1'b1, 1'b1, sc);
    pop_strobe(0, 20, found, o);
    n_checks++;
    if (!found || {o.d, o.pe, o.fe} !== {8'h11, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL after_break: got found=%b d=%h pe=%b fe=%b, required d=11 pe=0 fe=0",
               found, o.d, o.pe, o.fe);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_glitch();
    q.delete();
    line[0] = 1'b0;
    repeat (3) @(negedge clk);
    line[0] = 1'b1;
    repeat (3 * BC) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL glitch_strobe: got %0d strobes, required 0", q.size());
    end
    n_checks++;
    if ({df0, pe[0], fe[0]} !== {8'h11, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL glitch_hold: got d=%h pe=%b fe=%b, required d=11 pe=0 fe=0", df0, pe[0], fe[0]);
    end
  endtask

  task automatic test_back_to_back();
    int sc [2]; logic found; obs_t o;
    logic [7:0] vals [2];
    vals[0] = 8'h1F;
    vals[1] = 8'h00;
    q.delete();
    for (int f = 0; f < 2; f++) send_frame(2, vals[f], good_par(2, vals[f], 5), 1'b1, sc[f]);
    for (int f = 0; f < 2; f++) begin
      pop_strobe(2, 20, found, o);
      n_checks++;
      if (!found || {o.d, o.pe, o.fe} !== {vals[f], 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL b2b_frame%0d: got found=%b d=%h pe=%b fe=%b, required d=%h pe=0 fe=0",
                 f, found, o.d, o.pe, o.fe, vals[f]);
      end else begin
        n_checks++;
        if (o.cyc - sc[f] - 1 != exp_lat(5, 2)) begin
          n_fail++;
          $display("FAIL b2b_latency%0d: got %0d, required %0d", f, o.cyc - sc[f] - 1, exp_lat(5, 2));
        end
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_random();
    int sc, sel, fw, pm, gap; logic found; obs_t o;
    logic [7:0] data; logic pbit, stop_v, e_pe;
    for (int it = 0; it < 24; it++) begin
      sel    = $urandom_range(0, 2);
      fw     = FW_OF[sel];
      pm     = PM_OF[sel];
      data   = 8'($urandom) & 8'((1 << fw) - 1);
      pbit   = good_par(pm, data, fw) ^ ($urandom_range(0, 3) == 0);
      stop_v = ($urandom_range(0, 5) != 0);
      e_pe   = exp_perr(pm, data, fw, pbit);
      q.delete();
      send_frame(sel, data, pbit, stop_v, sc);
      pop_strobe(sel, 20, found, o);
      n_checks++;
      if (!found || {o.d, o.pe, o.fe} !== {data, e_pe, !stop_v}) begin
        n_fail++;
        $display("FAIL rand%0d inst%0d: got found=%b d=%h pe=%b fe=%b, required d=%h pe=%b fe=%b",
                 it, sel, found, o.d, o.pe, o.fe, data, e_pe, !stop_v);
      end else begin
        n_checks++;
        if (o.cyc - sc - 1 != exp_lat(fw, pm)) begin
          n_fail++;
          $display("FAIL rand%0d_latency: got %0d, required %0d", it, o.cyc - sc - 1, exp_lat(fw, pm));
        end
      end
      line[sel] = 1'b1;
      gap = stop_v ? $urandom_range(0, 12) : $urandom_range(2, 12);
      repeat (gap) @(negedge clk);
    end
    repeat (3 * BC) @(negedge clk);
  endtask

  task automatic test_rst_mid();
    int sc; logic found; obs_t o;
    q.delete();
    send_frame(0, 8'h3C, 1'b1, 1'b0, sc);
    line[0] = 1'b1;
    pop_strobe(0, 20, found, o);
    repeat (BC) @(negedge clk);
    n_checks++;
    if ({df0, fe[0]} !== {8'h3C, 1'b1}) begin
      n_fail++;
      $display("FAIL pre_rst_state: got d=%h fe=%b, required d=3c fe=1", df0, fe[0]);
    end
    q.delete();
    fork
      send_frame(0, 8'hF8, 1'b1, 1'b1, sc);
      begin
        repeat (4 * BC + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({df0, done[0], pe[0], fe[0]} !== 11'd0) begin
          n_fail++;
          $display("FAIL rst_outputs: got d=%h done=%b pe=%b fe=%b, required all 0",
                   df0, done[0], pe[0], fe[0]);
        end
      end
    join
    repeat (3 * BC) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_partial_strobe: got %0d strobes, required 0", q.size());
    end
    send_frame(0, 8'hC3, 1'b1, 1'b1, sc);
    pop_strobe(0, 20, found, o);
    n_checks++;
    if (!found || {o.d, o.pe, o.fe} !== {8'hC3, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL post_rst_frame: got found=%b d=%h pe=%b fe=%b, required d=c3 pe=0 fe=0",
               found, o.d, o.pe, o.fe);
    end else begin
      n_checks++;
      if (o.cyc - sc - 1 != exp_lat(8, 0)) begin
        n_fail++;
        $display("FAIL post_rst_latency: got %0d, required %0d", o.cyc - sc - 1, exp_lat(8, 0));
      end
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    line = 3'b111;
    @(negedge clk);
    test_reset();
    test_none_a5();
    test_odd_parity();
    test_break();
    test_glitch();
    test_back_to_back();
    test_random();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
